// File: rtl/spi_reg_pkg.sv
// ----------------------------------------------------------------------------
// spi_reg_pkg
// Shared constants for the SPI register peripheral: frame length, register
// address map and the receive FSM state type.
// ----------------------------------------------------------------------------
package spi_reg_pkg;

   localparam int FRAME_BITS = 16;

   localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
   localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/spi_reg_peripheral_sync_edge.sv
// ----------------------------------------------------------------------------
// sync_edge
// Brings one asynchronous pin into the clk domain through a SYNC_STAGES-deep
// flop chain, then one extra delay flop for edge detection.
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous active-high reset (chain clears to 0)
//   i_pin   in  asynchronous input pin
//   o_sync  out synchronized level
//   o_rise  out one-cycle pulse on a synchronized 0->1 transition
//   o_fall  out one-cycle pulse on a synchronized 1->0 transition
// ----------------------------------------------------------------------------
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_chain;
   logic                   r_dly;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chain <= '0;
         r_dly   <= 1'b0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-2:0], i_pin};
         r_dly   <= r_chain[SYNC_STAGES-1];
      end
   end

   assign o_sync = r_chain[SYNC_STAGES-1];
   assign o_rise = o_sync & ~r_dly;
   assign o_fall = ~o_sync & r_dly;

endmodule

// File: rtl/spi_reg_peripheral.sv
// ----------------------------------------------------------------------------
// spi_reg_peripheral
// Write-only SPI (mode 0, MSB first) slave holding the five 8-bit control
// registers of the PWM peripheral. Frame: [15] write flag, [14:8] address,
// [7:0] data. A frame commits only when exactly 16 bits (extra bits ignored)
// were shifted, the write flag is set and the address is implemented.
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   sclk, copi, ncs   asynchronous SPI pins
//   en_reg_out_7_0    register 0x00      en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0    register 0x02      en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle    register 0x04
//   wr_strobe         one-cycle pulse per committed write
//   busy              high while a frame is being received
// ----------------------------------------------------------------------------
module spi_reg_peripheral
   import spi_reg_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_REGS    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       busy
);

   logic w_sclk_sync_unused, w_sclk_rise, w_sclk_fall_unused;
   logic w_copi_sync, w_copi_rise_unused, w_copi_fall_unused;
   logic w_ncs_sync_unused, w_ncs_rise, w_ncs_fall;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(clk), .rst(rst), .i_pin(sclk),
      .o_sync(w_sclk_sync_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall_unused)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
      .clk(clk), .rst(rst), .i_pin(copi),
      .o_sync(w_copi_sync), .o_rise(w_copi_rise_unused), .o_fall(w_copi_fall_unused)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk(clk), .rst(rst), .i_pin(ncs),
      .o_sync(w_ncs_sync_unused), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
   );

   state_t      r_state;
   logic [4:0]  r_bit_cnt;
   logic [15:0] r_shift;
   logic        r_wr_strobe;
   logic [7:0]  r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_pwm_duty;

   logic [6:0]  w_addr;
   logic        w_commit;

   assign w_addr   = r_shift[14:8];
   // Full 7-bit compare: high addresses never alias onto implemented ones.
   assign w_commit = (r_bit_cnt == 5'(FRAME_BITS)) && r_shift[15] &&
                     (w_addr < 7'(NUM_REGS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_wr_strobe <= 1'b0;
         r_en_out_lo <= '0;
         r_en_out_hi <= '0;
         r_en_pwm_lo <= '0;
         r_en_pwm_hi <= '0;
         r_pwm_duty  <= '0;
      end else begin
         r_wr_strobe <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_ncs_fall) begin
                  r_bit_cnt <= '0;
                  r_shift   <= '0;
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               // End of frame takes priority over a coincident clock edge.
               if (w_ncs_rise) begin
                  r_state <= IDLE;
                  if (w_commit) begin
                     r_wr_strobe <= 1'b1;
                     case (w_addr)
                        ADDR_EN_OUT_7_0:  r_en_out_lo <= r_shift[7:0];
                        ADDR_EN_OUT_15_8: r_en_out_hi <= r_shift[7:0];
                        ADDR_EN_PWM_7_0:  r_en_pwm_lo <= r_shift[7:0];
                        ADDR_EN_PWM_15_8: r_en_pwm_hi <= r_shift[7:0];
                        ADDR_PWM_DUTY:    r_pwm_duty  <= r_shift[7:0];
                        default: ;
                     endcase
                  end
               end else if (w_sclk_rise && (r_bit_cnt < 5'(FRAME_BITS))) begin
                  // Count saturates at FRAME_BITS so trailing bits are dropped.
                  r_shift   <= {r_shift[14:0], w_copi_sync};
                  r_bit_cnt <= r_bit_cnt + 5'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign en_reg_out_7_0  = r_en_out_lo;
   assign en_reg_out_15_8 = r_en_out_hi;
   assign en_reg_pwm_7_0  = r_en_pwm_lo;
   assign en_reg_pwm_15_8 = r_en_pwm_hi;
   assign pwm_duty_cycle  = r_pwm_duty;
   assign wr_strobe       = r_wr_strobe;
   assign busy            = (r_state == SHIFT);

endmodule

// File: tb/tb_spi_reg_peripheral.sv
module tb_spi_reg_peripheral;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk, copi, ncs;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       wr_strobe, busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [6:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] model[5];

   always #5 clk = ~clk;

   spi_reg_peripheral #(.SYNC_STAGES(2), .NUM_REGS(5)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] dut_reg(input int a);
      case (a)
         0: return en_reg_out_7_0;
         1: return en_reg_out_15_8;
         2: return en_reg_pwm_7_0;
         3: return en_reg_pwm_15_8;
         4: return pwm_duty_cycle;
         default: return 8'hxx;
      endcase
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic check_image(input string tag);
      for (int a = 0; a < 5; a++) check($sformatf("%s_reg%0d", tag, a), dut_reg(a), model[a]);
   endtask

   task automatic model_reset();
      for (int a = 0; a < 5; a++) model[a] = 8'h00;
      exp_q.delete();
   endtask

   // Reference behaviour: the first 16 bits shifted form the frame; fewer
   // than 16 bits, a read flag or an address beyond the map discards it.
   task automatic model_frame(input logic [31:0] value, input int n);
      logic [15:0] f;
      wr_t w;
      if (n < 16) return;
      f = 16'(value >> (n - 16));
      if (f[15] == 1'b1 && int'(f[14:8]) < 5) begin
         model[f[14:8]] = f[7:0];
         w.addr = f[14:8];
         w.data = f[7:0];
         exp_q.push_back(w);
      end
   endtask

   task automatic frame_begin();
      ncs = 1'b0;
      wait_clks(4);
   endtask

   task automatic shift_bits(input logic [31:0] value, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         copi = value[i];
         wait_clks(4);
         sclk = 1'b1;
         wait_clks(4);
         sclk = 1'b0;
      end
   endtask

   task automatic frame_end(input logic [31:0] value, input int n, input bit live);
      wait_clks(4);
      if (live) begin
         @(negedge clk);
         check("busy_in_frame", busy, 1'b1);
         model_frame(value, n);
      end
      ncs = 1'b1;
      wait_clks(10);
      @(negedge clk);
      check("busy_after_frame", busy, 1'b0);
      check("strobe_missing_q", exp_q.size(), 0);
   endtask

   task automatic send(input logic [31:0] value, input int n);
      frame_begin();
      shift_bits(value, n - 1, 0);
      frame_end(value, n, 1'b1);
   endtask

   // Monitor: every strobe must match the oldest expected write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (wr_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL strobe_spurious: got strobe expected none at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("strobe_write_a%0d", e.addr), dut_reg(int'(e.addr)), e.data);
            end
         end
      end
   end

   initial begin
      logic [31:0] v;
      int          n;

      rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
      model_reset();
      wait_clks(3);
      @(negedge clk);
      check_image("reset");
      check("reset_strobe", wr_strobe, 1'b0);
      check("reset_busy", busy, 1'b0);
      rst = 1'b0;
      wait_clks(10);

      send(32'h80F0, 16); check_image("t2_out_lo");
      send(32'h8480, 16); check_image("t3_duty");
      send(32'h0000, 16); check_image("t3_read");
      send(32'h8555, 16); check_image("t4_addr5");
      send(32'hFF12, 16); check_image("t4_addr7f");
      send(32'h81AB >> 1, 15); check_image("t5_short");
      send((32'h81AB << 1) | 32'h1, 17); check_image("t5_long");

      for (int k = 0; k < 30; k++) begin
         v = $urandom;
         v[14:8] = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
         v[15] = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 4))
            0: n = 15;
            4: n = 17;
            default: n = 16;
         endcase
         v = (n == 16) ? {16'h0, v[15:0]} :
             (n == 17) ? {15'h0, v[15:0], 1'($urandom)} : {17'h0, v[15:1]};
         send(v, n);
         check_image($sformatf("rand%0d", k));
      end

      // Asynchronous reset mid-run, away from the clock edge.
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_image("t1_async");
      check("t1_strobe", wr_strobe, 1'b0);
      check("t1_busy", busy, 1'b0);
      wait_clks(3);
      rst = 1'b0;
      wait_clks(5);

      send(32'h8211, 16); check_image("pre_t6");

      // Reset after bit 8, release with ncs still low, finish the frame.
      frame_begin();
      shift_bits(32'h83CC, 15, 8);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_image("t6_rst");
      wait_clks(3);
      rst = 1'b0;
      shift_bits(32'h83CC, 7, 0);
      @(negedge clk);
      check("t6_busy_idle", busy, 1'b0);
      frame_end(32'h83CC, 16, 1'b0);
      check_image("t6_nowrite");

      send(32'h83CC, 16); check_image("t6_write");
      send(32'h8201, 16); check_image("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
